// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong datapath: ball FSM states,
// coordinate/velocity widths, span overlap and paddle speed-up.
package pong_pkg;

  localparam int COORD_W = 12;
  localparam int VEL_W   = 5;

  // Coordinates are widened by one bit so edge arithmetic cannot wrap.
  typedef logic signed [COORD_W:0]   coord_ext_t;
  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [VEL_W-1:0]   vel_t;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2
  } ball_state_e;

  function automatic logic overlap(input coord_ext_t a_lo, input coord_ext_t a_hi,
                                   input coord_ext_t b_lo, input coord_ext_t b_hi);
    return (a_lo <= b_hi) && (b_lo <= a_hi);
  endfunction

  // Magnitude grows by one up to vmax; direction is preserved.
  function automatic vel_t speed_up(input vel_t v, input int vmax);
    logic [VEL_W-1:0] mag;
    mag = v[VEL_W-1] ? -v : v;
    if (int'(mag) < vmax) mag = mag + VEL_W'(1);
    return v[VEL_W-1] ? -vel_t'(mag) : vel_t'(mag);
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// Combinational one-axis ball step. Without paddles the axis clamps and
// reflects at both walls; with paddles it bounces off paddle faces or misses.
module ball_axis_step
  import pong_pkg::*;
#(
  parameter int RES     = 1280,
  parameter int SIZE    = 16,
  parameter int PAD_H   = 20,
  parameter int VMAX    = 8,
  parameter bit PADDLES = 1'b0
) (
  input  coord_t pos_i,
  input  vel_t   vel_i,
  input  logic   lo_overlap_i,
  input  logic   hi_overlap_i,
  output coord_t pos_o,
  output vel_t   vel_o,
  output logic   hit_o,
  output logic   miss_lo_o,
  output logic   miss_hi_o
);

  localparam coord_ext_t ZERO    = '0;
  localparam coord_ext_t POS_MAX = coord_ext_t'(RES - SIZE);
  // Leading-edge resting positions against the low and high paddle faces.
  localparam coord_ext_t LO_STOP = coord_ext_t'(PAD_H);
  localparam coord_ext_t HI_STOP = coord_ext_t'(RES - PAD_H - SIZE);

  coord_ext_t cur;
  coord_ext_t nxt;

  assign cur = {pos_i[COORD_W-1], pos_i};
  assign nxt = cur + {{(COORD_W+1-VEL_W){vel_i[VEL_W-1]}}, vel_i};

  always_comb begin
    pos_o     = nxt[COORD_W-1:0];
    vel_o     = vel_i;
    hit_o     = 1'b0;
    miss_lo_o = 1'b0;
    miss_hi_o = 1'b0;
    if (!PADDLES) begin
      if (nxt <= ZERO) begin
        pos_o = ZERO[COORD_W-1:0];
        vel_o = -vel_i;
      end else if (nxt >= POS_MAX) begin
        pos_o = POS_MAX[COORD_W-1:0];
        vel_o = -vel_i;
      end
    end else if (vel_i[VEL_W-1]) begin
      if ((cur >= LO_STOP) && (nxt <= LO_STOP) && lo_overlap_i) begin
        pos_o = LO_STOP[COORD_W-1:0];
        vel_o = -speed_up(vel_i, VMAX);
        hit_o = 1'b1;
      end else if (nxt <= ZERO) begin
        pos_o     = pos_i;
        miss_lo_o = 1'b1;
      end
    end else begin
      if ((cur <= HI_STOP) && (nxt >= HI_STOP) && hi_overlap_i) begin
        pos_o = HI_STOP[COORD_W-1:0];
        vel_o = -speed_up(vel_i, VMAX);
        hit_o = 1'b1;
      end else if (nxt >= POS_MAX) begin
        pos_o     = pos_i;
        miss_hi_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Ball physics and render: per-frame position/velocity update with wall and
// paddle reflection, serve/play/miss rally control, and ball pixel colour.
module ball_engine
  import pong_pkg::*;
#(
  parameter int          HRES         = 1280,
  parameter int          VRES         = 720,
  parameter logic [23:0] COLOR        = 24'h00FF90,
  parameter int          BALL_SIZE    = 16,
  parameter int          PADDLE_H     = 20,
  parameter int          PADDLE_W     = 160,
  parameter int          VEL_INIT     = 2,
  parameter int          VEL_MAX      = 8,
  parameter int          SERVE_FRAMES = 60
) (
  input  logic                      pixel_clk,
  input  logic                      rst_n,
  input  logic                      fsync,
  input  logic signed [COORD_W-1:0] hpos,
  input  logic signed [COORD_W-1:0] vpos,
  input  logic signed [COORD_W-1:0] paddle_top_x,
  input  logic signed [COORD_W-1:0] paddle_bot_x,
  output logic [7:0]                pixel [0:2],
  output logic                      active,
  output logic                      miss_top,
  output logic                      miss_bot,
  output logic [7:0]                rally,
  output logic [1:0]                state
);

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam coord_t     LH_RST   = coord_t'(HRES / 2 - BALL_SIZE / 2);
  localparam coord_t     TV_RST   = coord_t'(VRES / 2 - BALL_SIZE / 2);
  localparam vel_t       V_INIT   = vel_t'(VEL_INIT);
  localparam coord_ext_t BALL_EXT = coord_ext_t'(BALL_SIZE - 1);
  localparam coord_ext_t PAD_EXT  = coord_ext_t'(PADDLE_W - 1);

  ball_state_e      state_q;
  coord_t           lh_q;
  coord_t           tv_q;
  vel_t             vh_q;
  vel_t             vv_q;
  logic [CNT_W-1:0] serve_cnt_q;
  logic [1:0]       lfsr_q;
  logic [7:0]       rally_q;
  logic             miss_top_q;
  logic             miss_bot_q;

  coord_t lh_d;
  coord_t tv_d;
  vel_t   vh_wall_d;
  vel_t   vh_d;
  vel_t   vv_d;
  logic   h_hit, h_miss_lo, h_miss_hi;
  logic   v_hit, v_miss_lo, v_miss_hi;
  logic   top_ov, bot_ov;
  logic   paddle_hit, miss_lo, miss_hi;

  ball_axis_step #(
    .RES(HRES), .SIZE(BALL_SIZE), .PAD_H(0), .VMAX(VEL_MAX), .PADDLES(1'b0)
  ) u_step_h (
    .pos_i        (lh_q),
    .vel_i        (vh_q),
    .lo_overlap_i (1'b0),
    .hi_overlap_i (1'b0),
    .pos_o        (lh_d),
    .vel_o        (vh_wall_d),
    .hit_o        (h_hit),
    .miss_lo_o    (h_miss_lo),
    .miss_hi_o    (h_miss_hi)
  );

  // Paddle overlap is judged against the horizontally updated position.
  coord_ext_t lh_new_ext, ptop_ext, pbot_ext;
  assign lh_new_ext = {lh_d[COORD_W-1], lh_d};
  assign ptop_ext   = {paddle_top_x[COORD_W-1], paddle_top_x};
  assign pbot_ext   = {paddle_bot_x[COORD_W-1], paddle_bot_x};
  assign top_ov = overlap(lh_new_ext, lh_new_ext + BALL_EXT, ptop_ext, ptop_ext + PAD_EXT);
  assign bot_ov = overlap(lh_new_ext, lh_new_ext + BALL_EXT, pbot_ext, pbot_ext + PAD_EXT);

  ball_axis_step #(
    .RES(VRES), .SIZE(BALL_SIZE), .PAD_H(PADDLE_H), .VMAX(VEL_MAX), .PADDLES(1'b1)
  ) u_step_v (
    .pos_i        (tv_q),
    .vel_i        (vv_q),
    .lo_overlap_i (top_ov),
    .hi_overlap_i (bot_ov),
    .pos_o        (tv_d),
    .vel_o        (vv_d),
    .hit_o        (v_hit),
    .miss_lo_o    (v_miss_lo),
    .miss_hi_o    (v_miss_hi)
  );

  assign paddle_hit = v_hit | h_hit;
  assign miss_lo    = v_miss_lo | h_miss_lo;
  assign miss_hi    = v_miss_hi | h_miss_hi;
  assign vh_d       = paddle_hit ? speed_up(vh_wall_d, VEL_MAX) : vh_wall_d;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q     <= SERVE;
      lh_q        <= LH_RST;
      tv_q        <= TV_RST;
      vh_q        <= '0;
      vv_q        <= '0;
      serve_cnt_q <= '0;
      lfsr_q      <= 2'b01;
      rally_q     <= '0;
      miss_top_q  <= 1'b0;
      miss_bot_q  <= 1'b0;
    end else begin
      miss_top_q <= 1'b0;
      miss_bot_q <= 1'b0;
      if (fsync) begin
        lfsr_q <= {lfsr_q[0], lfsr_q[1] ^ lfsr_q[0]};
        case (state_q)
          SERVE: begin
            lh_q <= LH_RST;
            tv_q <= TV_RST;
            if (serve_cnt_q == SERVE_LAST) begin
              vh_q        <= lfsr_q[0] ? -V_INIT : V_INIT;
              vv_q        <= lfsr_q[1] ? -V_INIT : V_INIT;
              serve_cnt_q <= '0;
              rally_q     <= '0;
              state_q     <= PLAY;
            end else begin
              vh_q        <= '0;
              vv_q        <= '0;
              serve_cnt_q <= serve_cnt_q + CNT_W'(1);
            end
          end
          PLAY: begin
            if (miss_lo || miss_hi) begin
              // Ball stays where it was; only the pulse and state move.
              miss_top_q <= miss_lo;
              miss_bot_q <= miss_hi;
              state_q    <= MISS;
            end else begin
              lh_q <= lh_d;
              tv_q <= tv_d;
              vh_q <= vh_d;
              vv_q <= vv_d;
              if (paddle_hit && (rally_q != 8'hFF)) rally_q <= rally_q + 8'd1;
            end
          end
          MISS: begin
            lh_q        <= LH_RST;
            tv_q        <= TV_RST;
            vh_q        <= '0;
            vv_q        <= '0;
            serve_cnt_q <= '0;
            state_q     <= SERVE;
          end
          default: state_q <= SERVE;
        endcase
      end
    end
  end

  coord_ext_t hpos_ext, vpos_ext, lh_ext, tv_ext;
  assign hpos_ext = {hpos[COORD_W-1], hpos};
  assign vpos_ext = {vpos[COORD_W-1], vpos};
  assign lh_ext   = {lh_q[COORD_W-1], lh_q};
  assign tv_ext   = {tv_q[COORD_W-1], tv_q};

  assign active = (hpos_ext >= lh_ext) && (hpos_ext <= lh_ext + BALL_EXT) &&
                  (vpos_ext >= tv_ext) && (vpos_ext <= tv_ext + BALL_EXT);

  assign pixel[0] = active ? COLOR[7:0]   : 8'h00;
  assign pixel[1] = active ? COLOR[15:8]  : 8'h00;
  assign pixel[2] = active ? COLOR[23:16] : 8'h00;

  assign miss_top = miss_top_q;
  assign miss_bot = miss_bot_q;
  assign rally    = rally_q;
  assign state    = state_q;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: one long hand-traced rally from reset,
// probing the ball position through active at its corners after each step.
module tb_ball_engine;

  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_MISS  = 2'd2;

  logic               pixel_clk;
  logic               rst_n;
  logic               fsync;
  logic signed [11:0] hpos, vpos, paddle_top_x, paddle_bot_x;
  logic [7:0]         pixel [0:2];
  logic               active, miss_top, miss_bot;
  logic [7:0]         rally;
  logic [1:0]         state;

  int checks   = 0;
  int failures = 0;

  ball_engine dut (
    .pixel_clk    (pixel_clk),
    .rst_n        (rst_n),
    .fsync        (fsync),
    .hpos         (hpos),
    .vpos         (vpos),
    .paddle_top_x (paddle_top_x),
    .paddle_bot_x (paddle_bot_x),
    .pixel        (pixel),
    .active       (active),
    .miss_top     (miss_top),
    .miss_bot     (miss_bot),
    .rally        (rally),
    .state        (state)
  );

  // clock / reset
  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic do_reset();
    rst_n = 1'b0;
    fsync = 1'b0;
    repeat (3) @(negedge pixel_clk);
    rst_n = 1'b1;
  endtask

  // checking
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // drivers
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pixel_clk);
      fsync = 1'b1;
    end
    @(negedge pixel_clk);
    fsync = 1'b0;
  endtask

  task automatic idle();
    @(negedge pixel_clk);
  endtask

  task automatic probe(input string tag, input int h, input int v, input logic exp);
    @(negedge pixel_clk);
    hpos = 12'(h);
    vpos = 12'(v);
    #1;
    chk(tag, 32'(active), 32'(exp));
  endtask

  task automatic check_pos(input string tag, input int lh, input int tv);
    probe({tag, "_tl"},    lh,      tv,      1'b1);
    probe({tag, "_br"},    lh + 15, tv + 15, 1'b1);
    probe({tag, "_left"},  lh - 1,  tv,      1'b0);
    probe({tag, "_above"}, lh,      tv - 1,  1'b0);
    probe({tag, "_right"}, lh + 16, tv + 15, 1'b0);
    probe({tag, "_below"}, lh + 15, tv + 16, 1'b0);
  endtask

  initial begin
    hpos = '0;
    vpos = '0;
    paddle_top_x = 12'sd0;
    paddle_bot_x = 12'sd0;
    do_reset();

    chk("rst_state", 32'(state), 32'(ST_SERVE));
    chk("rst_rally", 32'(rally), 32'd0);
    chk("rst_miss_top", 32'(miss_top), 32'd0);
    chk("rst_miss_bot", 32'(miss_bot), 32'd0);
    check_pos("rst", 632, 352);
    probe("pix_in_active", 640, 360, 1'b1);
    chk("pix_b", 32'(pixel[0]), 32'h90);
    chk("pix_g", 32'(pixel[1]), 32'hFF);
    chk("pix_r", 32'(pixel[2]), 32'h00);
    probe("pix_out_active", 648, 352, 1'b0);
    chk("pix_out_g", 32'(pixel[1]), 32'h00);

    // Serve: 59 frames rest, the 60th launches with vh=+2, vv=-2.
    frames(59);
    chk("serve59_state", 32'(state), 32'(ST_SERVE));
    check_pos("serve59", 632, 352);
    frames(1);
    chk("serve_go_state", 32'(state), 32'(ST_PLAY));
    chk("serve_go_rally", 32'(rally), 32'd0);
    check_pos("serve_go", 632, 352);
    frames(1);
    check_pos("play1", 634, 350);

    // Top paddle hit at tv 22 -> 20, speeds become 3.
    paddle_top_x = 12'sd964;
    paddle_bot_x = 12'sd898;
    frames(164);
    check_pos("pre_hit1", 962, 22);
    chk("pre_hit1_rally", 32'(rally), 32'd0);
    frames(1);
    check_pos("hit1", 964, 20);
    chk("hit1_rally", 32'(rally), 32'd1);
    frames(1);
    check_pos("post_hit1", 967, 23);

    // Right wall: nh reaches 1264 exactly, clamps and reflects, no miss.
    frames(98);
    check_pos("pre_wall_r", 1261, 317);
    frames(1);
    check_pos("wall_r", 1264, 320);
    chk("wall_r_state", 32'(state), 32'(ST_PLAY));
    chk("wall_r_miss_top", 32'(miss_top), 32'd0);
    chk("wall_r_miss_bot", 32'(miss_bot), 32'd0);
    frames(1);
    check_pos("post_wall_r", 1261, 323);

    // Bottom paddle hit: ball lands with bottom row 699.
    frames(120);
    check_pos("pre_hit2", 901, 683);
    frames(1);
    check_pos("hit2", 898, 684);
    chk("hit2_rally", 32'(rally), 32'd2);

    paddle_top_x = 12'sd234;
    frames(166);
    check_pos("hit3", 234, 20);
    chk("hit3_rally", 32'(rally), 32'd3);

    paddle_bot_x = 12'sd430;
    frames(47);
    check_pos("wall_l", 0, 255);
    frames(86);
    check_pos("hit4", 430, 684);
    chk("hit4_rally", 32'(rally), 32'd4);

    paddle_top_x = 12'sd1096;
    frames(111);
    check_pos("hit5", 1096, 20);
    chk("hit5_rally", 32'(rally), 32'd5);

    paddle_bot_x = 12'sd767;
    frames(95);
    check_pos("hit6", 767, 684);
    chk("hit6_rally", 32'(rally), 32'd6);

    // Speed already 8: a further hit keeps it at 8.
    paddle_top_x = 12'sd103;
    frames(83);
    check_pos("hit7", 103, 20);
    chk("hit7_rally", 32'(rally), 32'd7);
    frames(1);
    check_pos("saturated", 95, 28);

    // Bottom paddle out of reach: ball passes the face and misses.
    paddle_bot_x = 12'sd1000;
    frames(84);
    check_pos("pre_miss_b", 576, 700);
    chk("pre_miss_b_pulse", 32'(miss_bot), 32'd0);
    frames(1);
    chk("miss_b_pulse", 32'(miss_bot), 32'd1);
    chk("miss_b_other", 32'(miss_top), 32'd0);
    chk("miss_b_state", 32'(state), 32'(ST_MISS));
    idle();
    chk("miss_b_pulse_end", 32'(miss_bot), 32'd0);
    check_pos("frozen_b", 576, 700);

    frames(1);
    chk("recentre_state", 32'(state), 32'(ST_SERVE));
    chk("recentre_rally", 32'(rally), 32'd7);
    check_pos("recentre", 632, 352);

    // Second serve: lfsr is 01 here, so vh=-2, vv=+2.
    frames(60);
    chk("serve2_state", 32'(state), 32'(ST_PLAY));
    chk("serve2_rally", 32'(rally), 32'd0);
    paddle_top_x = 12'sd1100;
    paddle_bot_x = 12'sd300;
    frames(1);
    check_pos("serve2_1", 630, 354);
    frames(165);
    check_pos("hit_b", 300, 684);
    chk("hit_b_rally", 32'(rally), 32'd1);
    frames(100);
    check_pos("wall_l2", 0, 384);
    frames(127);
    check_pos("pre_miss_t", 381, 3);
    frames(1);
    chk("miss_t_pulse", 32'(miss_top), 32'd1);
    chk("miss_t_other", 32'(miss_bot), 32'd0);
    chk("miss_t_state", 32'(state), 32'(ST_MISS));
    idle();
    chk("miss_t_pulse_end", 32'(miss_top), 32'd0);
    check_pos("frozen_t", 381, 3);

    // Reset asserted together with fsync in the middle of a rally.
    frames(1);
    chk("serve3_state", 32'(state), 32'(ST_SERVE));
    frames(60);
    chk("serve3_play", 32'(state), 32'(ST_PLAY));
    frames(3);
    @(negedge pixel_clk);
    rst_n = 1'b0;
    fsync = 1'b1;
    @(negedge pixel_clk);
    rst_n = 1'b1;
    fsync = 1'b0;
    chk("rst_play_state", 32'(state), 32'(ST_SERVE));
    chk("rst_play_miss_top", 32'(miss_top), 32'd0);
    chk("rst_play_miss_bot", 32'(miss_bot), 32'd0);
    chk("rst_play_rally", 32'(rally), 32'd0);
    check_pos("rst_play", 632, 352);
    frames(60);
    chk("rst_serve_state", 32'(state), 32'(ST_PLAY));
    frames(1);
    check_pos("rst_lfsr", 634, 350);

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
